ddr_rst_seq: RTL

//  Generates init_rstn_mc, the DDR memory-controller soft-reset request consumed by the DDR CRG reset synchronizers.
//  On a soft reset request it runs one sequence:
//   - drive init_rstn_mc low;
//   - wait until the synchronized core and AXI resets (feedback) are seen low;
//   - hold low for a minimum time;
//   - release, then wait for both feedback resets to deassert;
//   - report done (or timeout).

---
 rtl/ddr_crg_pkg.sv | 16 +
 rtl/ddr_rst_seq_if.sv | 23 ++
 rtl/ddr_bit_sync.sv | 31 +++
 rtl/ddr_rst_seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ddr_crg_pkg.sv
// rtl/ddr_crg_pkg.sv - shared types and default constants for the DDR CRG reset sequencer
// Purpose: sequencer state encoding and default timing constants.
// Ports: none (package).
package ddr_crg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    HOLD     = 2'd2,
    WAIT_REL = 2'd3
  } rst_seq_state_e;

  localparam int DDR_RST_HOLD_CYC    = 16;
  localparam int DDR_RST_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/ddr_rst_seq_if.sv
// rtl/ddr_rst_seq_if.sv - request/status handshake between a soft-reset requester and the sequencer
// Purpose: groups the soft reset request and the sequencer status flags.
// Signals: soft_rst_req (requester->seq), rst_busy, rst_done, rst_timeout (seq->requester).
interface ddr_rst_seq_if;
  logic soft_rst_req;
  logic rst_busy;
  logic rst_done;
  logic rst_timeout;

  modport master (
    output soft_rst_req,
    input  rst_busy,
    input  rst_done,
    input  rst_timeout
  );

  modport slave (
    input  soft_rst_req,
    output rst_busy,
    output rst_done,
    output rst_timeout
  );
endinterface

// File: rtl/ddr_bit_sync.sv
// rtl/ddr_bit_sync.sv - multi-flop single-bit synchronizer with configurable reset value
// Purpose: brings an asynchronous level into the clk domain.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
module ddr_bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ddr_rst_seq.sv
// rtl/ddr_rst_seq.sv - DDR memory-controller soft-reset sequencer
// Purpose: on a soft reset request drives init_rstn_mc low, waits for the CRG
//   core/AXI reset feedback to assert, holds for HOLD_CYC, releases, waits for
//   the feedback to deassert, then reports done (or timeout).
// Ports: pclk, presetn (async active-low), scan_mode (forces init_rstn_mc high),
//   core_rstn_fb / axi_rstn_fb (async feedback), init_rstn_mc (registered request),
//   bus (slave: soft_rst_req in; rst_busy, rst_done, rst_timeout out).
module ddr_rst_seq
  import ddr_crg_pkg::*;
#(
  parameter int HOLD_CYC    = DDR_RST_HOLD_CYC,
  parameter int TIMEOUT_CYC = DDR_RST_TIMEOUT_CYC,
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic presetn,
  input  logic scan_mode,
  input  logic core_rstn_fb,
  input  logic axi_rstn_fb,
  output logic init_rstn_mc,
  ddr_rst_seq_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  if (HOLD_CYC < 1 || TIMEOUT_CYC <= HOLD_CYC || SYNC_STAGES < 2) begin : g_param_err
    $error("ddr_rst_seq: illegal HOLD_CYC/TIMEOUT_CYC/SYNC_STAGES combination");
  end

  logic fb_core_s;
  logic fb_axi_s;

  // Reset value 1 keeps an ack from being seen before the CRG really asserts.
  ddr_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_core (
    .clk   (pclk),
    .rst_n (presetn),
    .d     (core_rstn_fb),
    .q     (fb_core_s)
  );

  ddr_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_axi (
    .clk   (pclk),
    .rst_n (presetn),
    .d     (axi_rstn_fb),
    .q     (fb_axi_s)
  );

  rst_seq_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic init_q, init_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic tmo_q, tmo_d;

  logic cnt_at_timeout;
  logic cnt_at_hold;

  assign cnt_at_timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign cnt_at_hold    = (cnt_q == CNT_W'(HOLD_CYC - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    done_d  = 1'b0;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (bus.soft_rst_req) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          init_d  = 1'b0;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!fb_core_s && !fb_axi_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_at_timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
          init_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      HOLD: begin
        // Feedback is deliberately not looked at here; a bounce cannot cut the hold short.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_at_hold) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
          init_d  = 1'b1;
        end
      end
      WAIT_REL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fb_core_s && fb_axi_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (cnt_at_timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        init_d  = 1'b1;
      end
    endcase
    // Busy is registered from the next state so it never glitches on a
    // multi-bit state change.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      init_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign init_rstn_mc    = init_q | scan_mode;
  assign bus.rst_busy    = busy_q;
  assign bus.rst_done    = done_q;
  assign bus.rst_timeout = tmo_q;

endmodule
